// File: rtl/cache_refill_controller_pkg.sv
// Shared fetch package: refill FSM encoding and instruction-cache line geometry.
package cache_refill_controller_pkg;

  localparam int unsigned LINE_WORDS       = 4;
  localparam int unsigned FETCH_WORD_WIDTH = 32;
  localparam int unsigned LINE_WIDTH       = LINE_WORDS * FETCH_WORD_WIDTH;
  localparam int unsigned LINE_BYTES       = LINE_WIDTH / 8;
  localparam int unsigned LINE_OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned WORD_OFFSET_BITS = $clog2(FETCH_WORD_WIDTH / 8);
  localparam int unsigned WORD_IDX_BITS    = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } refill_state_e;

endpackage

// File: rtl/cache_refill_controller.sv
// Instruction-cache refill controller: fetches a 4-word line on a miss and
// hands it to the cache as a one-cycle line_valid pulse.
module cache_refill_controller
  import cache_refill_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WORD_WIDTH     = FETCH_WORD_WIDTH,
  parameter int unsigned WORDS_PER_LINE = LINE_WORDS
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 miss_req,
  input  logic [ADDR_WIDTH-1:0]                miss_addr,
  input  logic                                 flush,
  input  logic                                 mem_ready,
  input  logic [WORD_WIDTH-1:0]                mem_rdata,
  output logic                                 mem_req,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] line_data,
  output logic [ADDR_WIDTH-1:0]                line_addr,
  output logic                                 line_valid,
  output logic                                 stall,
  output logic [15:0]                          refill_count
);

  localparam int unsigned LINE_W = WORDS_PER_LINE * WORD_WIDTH;
  localparam logic [WORD_IDX_BITS-1:0] LAST_IDX = WORD_IDX_BITS'(WORDS_PER_LINE - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  refill_state_e             state_q, state_d;
  logic [WORD_IDX_BITS-1:0]  k_q, k_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [LINE_W-1:0]         shift_q, shift_d;
  logic [LINE_W-1:0]         line_data_q, line_data_d;
  logic [ADDR_WIDTH-1:0]     line_addr_q, line_addr_d;
  logic [15:0]               refill_count_q, refill_count_d;
  logic                      unused_offset;

  assign unused_offset = ^miss_addr[LINE_OFFSET_BITS-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      base_q         <= '0;
      shift_q        <= '0;
      line_data_q    <= '0;
      line_addr_q    <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      base_q         <= base_d;
      shift_q        <= shift_d;
      line_data_q    <= line_data_d;
      line_addr_q    <= line_addr_d;
      refill_count_q <= refill_count_d;
    end
  end

  // Words shift in from the bottom, so word 0 ends up in the top slot of the line.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    base_d         = base_q;
    shift_d        = shift_q;
    line_data_d    = line_data_q;
    line_addr_d    = line_addr_q;
    refill_count_d = refill_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_req && !flush) begin
          base_d  = {miss_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
          k_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          shift_d = {shift_q[LINE_W-WORD_WIDTH-1:0], mem_rdata};
          k_d     = k_q + WORD_IDX_BITS'(1);
          if (k_q == LAST_IDX) begin
            line_data_d = shift_d;
            line_addr_d = base_q;
            state_d     = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
        if (refill_count_q != COUNT_MAX) begin
          refill_count_d = refill_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req      = (state_q == ST_FETCH);
  assign mem_addr     = base_q + (ADDR_WIDTH'(k_q) << WORD_OFFSET_BITS);
  assign line_valid   = (state_q == ST_FILL);
  assign stall        = (state_q != ST_IDLE);
  assign line_data    = line_data_q;
  assign line_addr    = line_addr_q;
  assign refill_count = refill_count_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Bench for cache_refill_controller: directed refills plus randomized memory
// timing, checked against a line-level reference model.
module tb_cache_refill_controller;

  logic         clock;
  logic         reset_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         flush;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_valid;
  logic         stall;
  logic [15:0]  refill_count;

  int           nerr;
  int           nchk;
  logic [15:0]  exp_count;
  logic [127:0] last_line;
  logic [31:0]  last_addr;

  cache_refill_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .line_data    (line_data),
    .line_addr    (line_addr),
    .line_valid   (line_valid),
    .stall        (stall),
    .refill_count (refill_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, 128'(stall), 128'(0));
    chk({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    chk({tag, "_line_valid"}, 128'(line_valid), 128'(0));
    chk({tag, "_line_data"}, line_data, last_line);
    chk({tag, "_line_addr"}, 128'(line_addr), 128'(last_addr));
  endtask

  // One miss from IDLE, entered and left at a falling edge with the DUT idle.
  // mode: 0 ready always, 1 ready every 3rd cycle, 2 random ready.
  // flush_at: flush once this many words are accepted (-1 = never).
  // hold: keep miss_req high with hold_addr during and after the refill.
  task automatic refill(input logic [31:0] addr, input int mode, input int flush_at,
                        input logic [31:0] hold_addr, input logic hold);
    logic [31:0]  base;
    logic [31:0]  w [4];
    logic [127:0] line;
    int           acc;
    int           cyc;
    logic         done;
    logic         fl;
    logic         rdy;
    base = addr & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    line = {w[0], w[1], w[2], w[3]};
    chk_idle("idle");
    chk("idle_count", 128'(refill_count), 128'(exp_count));
    miss_req  = 1'b1;
    miss_addr = addr;
    flush     = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    acc  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clock);
      cyc++;
      miss_req  = hold | ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      miss_addr = hold ? hold_addr : $urandom;
      flush     = 1'b0;
      if (acc < 4) begin
        chk("fetch_mem_req", 128'(mem_req), 128'(1));
        chk("fetch_stall", 128'(stall), 128'(1));
        chk("fetch_line_valid", 128'(line_valid), 128'(0));
        chk("fetch_mem_addr", 128'(mem_addr), 128'(base + 32'(4 * acc)));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        fl = (acc == flush_at);
        if (fl) rdy = 1'b1;
        flush     = fl;
        mem_ready = rdy;
        mem_rdata = rdy ? w[acc] : $urandom;
        if (fl) begin
          @(negedge clock);
          flush     = 1'b0;
          mem_ready = 1'b0;
          miss_req  = 1'b0;
          chk_idle("flushed");
          done = 1'b1;
        end else if (rdy) begin
          acc++;
        end
      end else begin
        chk("fill_line_valid", 128'(line_valid), 128'(1));
        chk("fill_stall", 128'(stall), 128'(1));
        chk("fill_mem_req", 128'(mem_req), 128'(0));
        chk("fill_line_addr", 128'(line_addr), 128'(base));
        chk("fill_line_data", line_data, line);
        // Miss driven in cycle 1, FETCH in cycles 2-5, pulse in cycle 6.
        if (mode == 0) chk("fill_latency", 128'(cyc), 128'(5));
        flush     = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
        last_line = line;
        last_addr = base;
        @(negedge clock);
        flush     = 1'b0;
        miss_req  = hold;
        miss_addr = hold ? hold_addr : 32'h0;
        chk_idle("after_fill");
        done = 1'b1;
      end
    end
    if (!done) chk("refill_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int fa;
    nerr      = 0;
    nchk      = 0;
    exp_count = 16'h0;
    last_line = 128'h0;
    last_addr = 32'h0;
    reset_n   = 1'b0;
    miss_req  = 1'b0;
    miss_addr = 32'h0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    #2;
    chk_idle("reset");
    chk("reset_count", 128'(refill_count), 128'(0));
    chk("reset_mem_addr", 128'(mem_addr), 128'(0));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    refill(32'h0000_0048, 0, -1, 32'h0, 1'b0);
    chk("first_line_addr", 128'(line_addr), 128'(32'h40));
    refill(32'h0000_0048, 1, -1, 32'h0, 1'b0);

    refill(32'h1234_5678, 0, 2, 32'h0, 1'b0);
    refill(32'h0000_0ABC, 2, -1, 32'h0, 1'b0);

    // flush in IDLE blocks a simultaneous miss
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0500;
    flush     = 1'b1;
    @(negedge clock);
    miss_req = 1'b0;
    flush    = 1'b0;
    chk_idle("flush_blocks_miss");

    refill(32'h0000_0100, 0, -1, 32'h0000_0200, 1'b1);
    refill(32'h0000_0200, 0, -1, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      refill($urandom, 2, fa, 32'h0, 1'b0);
    end

    // asynchronous reset mid-FETCH
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0300;
    mem_ready = 1'b0;
    @(negedge clock);
    miss_req  = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    exp_count = 16'h0;
    last_line = 128'h0;
    last_addr = 32'h0;
    chk_idle("async_reset");
    chk("async_reset_count", 128'(refill_count), 128'(0));
    chk("async_reset_mem_addr", 128'(mem_addr), 128'(0));
    mem_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    refill(32'h0000_0300, 0, -1, 32'h0, 1'b0);

    // counter saturation
    force dut.refill_count_q = 16'hFFFE;
    @(posedge clock);
    @(negedge clock);
    release dut.refill_count_q;
    exp_count = 16'hFFFE;
    refill(32'h0000_0700, 0, -1, 32'h0, 1'b0);
    chk("count_reaches_max", 128'(refill_count), 128'(16'hFFFF));
    refill(32'h0000_0800, 2, -1, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    chk("count_saturated", 128'(refill_count), 128'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
